// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two registered read ports and a clear sequencer.
// Define REG_FILE_MP_BYPASS_EN for write-first forwarding on read/write collisions (default read-first).
module reg_file_mp #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int INIT_BASE = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WE,
    input  logic [$clog2(DEPTH)-1:0]   WADDR,
    input  logic [WIDTH-1:0]           WDATA,
    input  logic                       RE_A,
    input  logic [$clog2(DEPTH)-1:0]   RADDR_A,
    output logic [WIDTH-1:0]           DOUT_A,
    output logic                       RVALID_A,
    input  logic                       RE_B,
    input  logic [$clog2(DEPTH)-1:0]   RADDR_B,
    output logic [WIDTH-1:0]           DOUT_B,
    output logic                       RVALID_B,
    input  logic                       CLR,
    output logic                       BUSY
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  dout_a_q, dout_b_q;
    logic              rvalid_a_q, rvalid_b_q;
    logic              wr_ok;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        return WIDTH'(INIT_BASE + i);
    endfunction

    // DEPTH need not be a power of two, so the top of the address space can be unmapped.
    function automatic logic in_rng(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (in_rng(a)) begin
            v = regs_q[a];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_ok && (WADDR == a)) v = WDATA;
`endif
        end
        return v;
    endfunction

    assign wr_ok = WE && (state_q == IDLE) && in_rng(WADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear writes own the array while busy; user writes during CLEAR are simply lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= init_val(i);
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= init_val(int'(cnt_q));
        end else if (wr_ok) begin
            regs_q[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= RE_A;
            rvalid_b_q <= RE_B;
            if (RE_A) dout_a_q <= rd_val(RADDR_A);
            if (RE_B) dout_b_q <= rd_val(RADDR_B);
        end
    end

    assign DOUT_A   = dout_a_q;
    assign DOUT_B   = dout_b_q;
    assign RVALID_A = rvalid_a_q;
    assign RVALID_B = rvalid_b_q;
    assign BUSY     = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised + directed bench for reg_file_mp: a 4x8 (base 2) and a 6x8 (base 0xFE) instance
// driven in lockstep and compared every cycle against an array-based reference model.
module tb_reg_file_mp;
    logic       CLK = 1'b0;
    logic       RST;
    logic       WE, RE_A, RE_B, CLR;
    logic [2:0] WADDR, RADDR_A, RADDR_B;
    logic [7:0] WDATA;
    logic [7:0] da0, db0, da1, db1;
    logic       va0, vb0, va1, vb1, bz0, bz1;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    reg_file_mp #(.WIDTH(8), .DEPTH(4), .INIT_BASE(2)) u4 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR[1:0]), .WDATA(WDATA),
        .RE_A(RE_A), .RADDR_A(RADDR_A[1:0]), .DOUT_A(da0), .RVALID_A(va0),
        .RE_B(RE_B), .RADDR_B(RADDR_B[1:0]), .DOUT_B(db0), .RVALID_B(vb0),
        .CLR(CLR), .BUSY(bz0)
    );

    reg_file_mp #(.WIDTH(8), .DEPTH(6), .INIT_BASE(254)) u6 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE_A(RE_A), .RADDR_A(RADDR_A), .DOUT_A(da1), .RVALID_A(va1),
        .RE_B(RE_B), .RADDR_B(RADDR_B), .DOUT_B(db1), .RVALID_B(vb1),
        .CLR(CLR), .BUSY(bz1)
    );

    // reference model: per instance, memory array plus index of the next clear write (-1 = idle)
    int         dep  [2] = '{4, 6};
    int         base [2] = '{2, 254};
    logic [7:0] mem  [2][8];
    int         cidx [2];
    logic [7:0] ed   [2][2];
    logic       ev   [2][2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] initv(input int k, input int i);
        return 8'((base[k] + i) % 256);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = (i < dep[k]) ? initv(k, i) : 8'h00;
            cidx[k] = -1;
            for (int p = 0; p < 2; p++) begin
                ed[k][p] = 8'h00;
                ev[k][p] = 1'b0;
            end
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            int  wa, ra[2];
            bit  re[2], busy, wacc;
            wa    = (k == 0) ? int'(WADDR[1:0]) : int'(WADDR);
            ra[0] = (k == 0) ? int'(RADDR_A[1:0]) : int'(RADDR_A);
            ra[1] = (k == 0) ? int'(RADDR_B[1:0]) : int'(RADDR_B);
            re[0] = RE_A;
            re[1] = RE_B;
            busy  = (cidx[k] >= 0);
            wacc  = WE && !busy && (wa < dep[k]);
            for (int p = 0; p < 2; p++) begin
                ev[k][p] = re[p];
                if (re[p]) begin
                    if (ra[p] >= dep[k])                 ed[k][p] = 8'h00;
                    else if (BYP && wacc && wa == ra[p]) ed[k][p] = WDATA;
                    else                                 ed[k][p] = mem[k][ra[p]];
                end
            end
            if (busy) begin
                mem[k][cidx[k]] = initv(k, cidx[k]);
                cidx[k] = (cidx[k] == dep[k] - 1) ? -1 : cidx[k] + 1;
            end else begin
                if (wacc) mem[k][wa] = WDATA;
                if (CLR)  cidx[k] = 0;
            end
        end
    endtask

    task automatic m_check();
        chk("u4 DOUT_A",   32'(da0), 32'(ed[0][0]));
        chk("u4 DOUT_B",   32'(db0), 32'(ed[0][1]));
        chk("u4 RVALID_A", 32'(va0), 32'(ev[0][0]));
        chk("u4 RVALID_B", 32'(vb0), 32'(ev[0][1]));
        chk("u4 BUSY",     32'(bz0), 32'(cidx[0] >= 0));
        chk("u6 DOUT_A",   32'(da1), 32'(ed[1][0]));
        chk("u6 DOUT_B",   32'(db1), 32'(ed[1][1]));
        chk("u6 RVALID_A", 32'(va1), 32'(ev[1][0]));
        chk("u6 RVALID_B", 32'(vb1), 32'(ev[1][1]));
        chk("u6 BUSY",     32'(bz1), 32'(cidx[1] >= 0));
    endtask

    task automatic drv(input logic we, input int wa, input logic [7:0] wd,
                       input logic rea, input int raa, input logic reb, input int rab,
                       input logic clr);
        WE = we; WADDR = 3'(wa); WDATA = wd;
        RE_A = rea; RADDR_A = 3'(raa); RE_B = reb; RADDR_B = 3'(rab); CLR = clr;
        @(posedge CLK);
        m_step();
        #1;
        m_check();
    endtask

    task automatic async_reset();
        RST = 1'b1;
        #1;
        chk("rst BUSY",   32'(bz0), 32'd0);
        chk("rst DOUT_A", 32'(da0), 32'd0);
        chk("rst RVAL_A", 32'(va0), 32'd0);
        m_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int nb0, nb1;
        WE = 0; WADDR = 0; WDATA = 0; RE_A = 0; RADDR_A = 0; RE_B = 0; RADDR_B = 0; CLR = 0;
        async_reset();

        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 8'h00, 1, i, 1, 3 - i, 0);
            chk("init A u4", 32'(da0), 32'(2 + i));
            chk("init B u4", 32'(db0), 32'(5 - i));
            chk("init A u6", 32'(da1), 32'((254 + i) % 256));
        end

        drv(1, 1, 8'hA5, 0, 0, 0, 0, 0);
        drv(1, 2, 8'h3C, 1, 2, 0, 0, 0);
        chk("collision", 32'(da0), BYP ? 32'h3C : 32'h04);
        drv(0, 0, 8'h00, 1, 2, 1, 1, 0);
        chk("after coll", 32'(da0), 32'h3C);
        chk("R1 write",   32'(db0), 32'hA5);

        drv(1, 6, 8'h77, 0, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 1, 7, 1, 6, 0);
        chk("oob A u6",  32'(da1), 32'h00);
        chk("oob vA u6", 32'(va1), 32'd1);
        for (int i = 0; i < 6; i++) drv(0, 0, 8'h00, 1, i, 1, 5 - i, 0);

        // clear with a write attempt during busy
        for (int i = 0; i < 6; i++) drv(1, i, 8'h11, 0, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 0, 0, 0, 0, 1);
        nb0 = 0; nb1 = 0;
        for (int c = 0; c < 10; c++) begin
            nb0 += int'(bz0);
            nb1 += int'(bz1);
            drv(bz0, 3, 8'h99, 1, 3, 0, 0, 0);
        end
        chk("busy len u4", 32'(nb0), 32'd4);
        chk("busy len u6", 32'(nb1), 32'd6);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 8'h00, 1, i, 0, 0, 0);
            chk("post clr", 32'(da0), 32'(2 + i));
        end

        // reset two cycles into a clear, after the bench overwrote registers
        for (int i = 0; i < 6; i++) drv(1, i, 8'h5A, 0, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 1, 3, 0, 0, 1);
        drv(0, 0, 8'h00, 1, 3, 0, 0, 0);
        drv(0, 0, 8'h00, 1, 3, 0, 0, 0);
        #2;
        async_reset();
        for (int i = 0; i < 6; i++) drv(0, 0, 8'h00, 1, i, 1, i, 0);
        drv(0, 0, 8'h00, 0, 0, 0, 0, 1);
        for (int c = 0; c < 8; c++) drv(0, 0, 8'h00, 1, c % 6, 0, 0, 0);

        // hold behaviour
        drv(0, 0, 8'h00, 1, 3, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drv(0, 0, 8'h00, 0, 0, 0, 0, 0);
            chk("hold data",  32'(da0), 32'h05);
            chk("hold valid", 32'(va0), 32'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            drv(($urandom % 2) == 0, int'($urandom % 8), 8'($urandom),
                ($urandom % 4) != 0, int'($urandom % 8),
                ($urandom % 4) != 0, int'($urandom % 8),
                ($urandom % 30) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
